cmd_parser: RTL and testbench
=============================

CMD_PARSER -- requirements
Module: cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 100000, idle clock cycles between bytes of a long command before abort.
REQ-002 SHALL have port clk_i, input, 1, single system clock; all logic rising-edge.
REQ-003 SHALL have port rst_in, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port rx_stb_i, input, 1, one-cycle strobe: rx_dat_i valid from the UART receiver.
REQ-005 SHALL have port rx_dat_i, input, 8, received byte.
REQ-006 SHALL have port stb_o, output, 1, one-cycle strobe: opc_o/cmd_o hold a complete command for the instruction decoder.
REQ-007 SHALL have port opc_o, output, 8, command opcode.
REQ-008 SHALL have port cmd_o, output, 32, command argument; zero for short commands.
REQ-009 SHALL have port busy_o, output, 1, high while a long command is partially received.
REQ-010 SHALL have port err_o, output, 1, one-cycle pulse on timeout abort.

Function
REQ-011 SHALL classify an opcode byte with bit 7 = 0 as short (1 byte) and bit 7 = 1 as long (opcode + 4 argument bytes).
REQ-012 SHALL implement FSM states IDLE and ARG, with a 2-bit argument index 0..3.
REQ-013 IDLE + rx_stb_i with a short opcode: latch opc_o, set cmd_o = 0, assert stb_o the next cycle, remain IDLE.
REQ-014 IDLE + rx_stb_i with a long opcode: latch opc_o, clear the index, go to ARG; no stb_o.
REQ-015 In ARG, each rx_stb_i SHALL store the byte in cmd_o[8*idx+7:8*idx] (first argument byte = LSB) and increment idx.
REQ-016 The 4th argument byte SHALL assert stb_o the cycle after it is accepted and return to IDLE; latency is 1 cycle from the last byte.
REQ-017 opc_o/cmd_o SHALL stay stable from the stb_o cycle until the next opcode byte is accepted.
REQ-018 SHALL accept back-to-back bytes, one per cycle, without loss, including a new opcode in the cycle stb_o is high.
REQ-019 In ARG, a cycle counter SHALL restart on every accepted byte; reaching TIMEOUT_CYC-1 cycles without a byte SHALL pulse err_o, return to IDLE, and suppress stb_o.
REQ-020 If the timeout and rx_stb_i coincide, the byte SHALL win: it is accepted and the counter restarts, with no err_o.
REQ-021 busy_o SHALL equal (state == ARG).
REQ-022 Timeout counter width SHALL be $clog2(TIMEOUT_CYC); it is held at 0 in IDLE.

Reset
REQ-023 While rst_in = 0: state IDLE, idx 0, counter 0, stb_o 0, err_o 0, busy_o 0, opc_o 0x00, cmd_o 0x00000000.
REQ-024 Reset asserted during ARG SHALL discard the partial command; no stb_o or err_o follows release.
REQ-025 The first byte after reset release SHALL be treated as an opcode.

Configuration
REQ-026 Macro CMD_PARSER_TIMEOUT_EN defined: timeout logic per REQ-019/020/022 is present.
REQ-027 Macro undefined: no counter; ARG waits indefinitely for argument bytes; err_o is tied to 0; TIMEOUT_CYC is ignored.

Structure
REQ-028 The shared logIP package SHALL hold the opcode-width constant (8), the argument-width constant (32), the long-opcode flag bit index (7), and the FSM state enum.
REQ-029 No sub-module; the block is one FSM plus a shift/index register and a counter, and its outputs connect directly to the instruction decoder's stb_i/opc_i/cmd_i.

Verification
REQ-030 Byte 0x00 -> one cycle later stb_o = 1, opc_o = 0x00, cmd_o = 0x00000000, busy_o = 0.
REQ-031 Bytes 0xC0,0x11,0x22,0x33,0x44 on consecutive cycles -> one stb_o with opc_o = 0xC0, cmd_o = 0x44332211, one cycle after 0x44.
REQ-032 Bytes 0x80,0xAA, then a gap of TIMEOUT_CYC cycles (macro defined) -> err_o pulses once, no stb_o; then 0x02 -> stb_o with opc_o = 0x02.
REQ-033 Byte arrives exactly on the timeout cycle -> no err_o, and the command completes normally with correct cmd_o.
REQ-034 rst_in low after 0xC1,0x01 -> outputs at reset values; after release, 0x01 -> short-command stb_o with opc_o = 0x01.
REQ-035 Five consecutive 0x00 bytes -> five stb_o pulses, each opc_o = 0x00.

Source files
------------

// File: rtl/cmd_parser_pkg.sv
// Shared constants and FSM state type for the UART command parser.
package cmd_parser_pkg;

   localparam int OPC_W    = 8;
   localparam int ARG_W    = 32;
   localparam int LONG_BIT = 7;

   typedef enum logic {
      IDLE = 1'b0,
      ARG  = 1'b1
   } state_t;

endpackage

// File: rtl/cmd_parser.sv
// Assembles UART bytes into short (1-byte) or long (opcode + 4-byte LSB-first) commands.
// Optional inter-byte timeout for long commands: define CMD_PARSER_TIMEOUT_EN.
module cmd_parser
   import cmd_parser_pkg::*;
#(
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic             clk_i,
   input  logic             rst_in,
   input  logic             rx_stb_i,
   input  logic [OPC_W-1:0] rx_dat_i,
   output logic             stb_o,
   output logic [OPC_W-1:0] opc_o,
   output logic [ARG_W-1:0] cmd_o,
   output logic             busy_o,
   output logic             err_o
);

   generate
      if (TIMEOUT_CYC < 2) begin : g_bad_timeout
         $error("cmd_parser: TIMEOUT_CYC must be at least 2");
      end
   endgenerate

   state_t     state;
   logic [1:0] idx;

`ifdef CMD_PARSER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt;
`else
   assign err_o = 1'b0;
`endif

   assign busy_o = (state == ARG);

   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         state <= IDLE;
         idx   <= 2'd0;
         stb_o <= 1'b0;
         opc_o <= '0;
         cmd_o <= '0;
`ifdef CMD_PARSER_TIMEOUT_EN
         cnt   <= '0;
         err_o <= 1'b0;
`endif
      end else begin
         stb_o <= 1'b0;
`ifdef CMD_PARSER_TIMEOUT_EN
         err_o <= 1'b0;
         cnt   <= '0;
`endif
         case (state)
            IDLE: begin
               if (rx_stb_i) begin
                  opc_o <= rx_dat_i;
                  idx   <= 2'd0;
                  if (rx_dat_i[LONG_BIT]) begin
                     state <= ARG;
                  end else begin
                     cmd_o <= '0;
                     stb_o <= 1'b1;
                  end
               end
            end
            ARG: begin
               // An arriving byte always takes priority over a timeout in the same cycle.
               if (rx_stb_i) begin
                  cmd_o[{idx, 3'b000} +: 8] <= rx_dat_i;
                  idx <= idx + 2'd1;
                  if (idx == 2'd3) begin
                     stb_o <= 1'b1;
                     state <= IDLE;
                  end
               end
`ifdef CMD_PARSER_TIMEOUT_EN
               else if (cnt == CNT_LAST) begin
                  err_o <= 1'b1;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_parser.sv
// Randomized and directed bench for cmd_parser against a byte-queue reference model.
module tb_cmd_parser;

   localparam int TO = 8;
`ifdef CMD_PARSER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk_i    = 1'b0;
   logic        rst_in   = 1'b0;
   logic        rx_stb_i = 1'b0;
   logic [7:0]  rx_dat_i = 8'h00;
   logic        stb_o;
   logic [7:0]  opc_o;
   logic [31:0] cmd_o;
   logic        busy_o;
   logic        err_o;

   cmd_parser #(.TIMEOUT_CYC(TO)) dut (
      .clk_i    (clk_i),
      .rst_in   (rst_in),
      .rx_stb_i (rx_stb_i),
      .rx_dat_i (rx_dat_i),
      .stb_o    (stb_o),
      .opc_o    (opc_o),
      .cmd_o    (cmd_o),
      .busy_o   (busy_o),
      .err_o    (err_o)
   );

   always #5 clk_i = ~clk_i;

   int nchk = 0;
   int nerr = 0;

   // Reference state: bytes of the long command in progress and idle cycles since the last one.
   logic [7:0]  pend[$];
   int          idle = 0;
   logic        exp_stb, exp_err, exp_busy;
   logic [7:0]  exp_opc;
   logic [31:0] exp_cmd;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model(input logic s, input logic [7:0] d);
      exp_stb = 1'b0;
      exp_err = 1'b0;
      if (s) begin
         idle = 0;
         if (pend.size() == 0) begin
            if (!d[7]) begin
               exp_stb = 1'b1;
               exp_opc = d;
               exp_cmd = 32'h0;
            end else begin
               pend.push_back(d);
            end
         end else begin
            pend.push_back(d);
            if (pend.size() == 5) begin
               exp_stb = 1'b1;
               exp_opc = pend[0];
               exp_cmd = {pend[4], pend[3], pend[2], pend[1]};
               pend.delete();
            end
         end
      end else if (pend.size() != 0) begin
         idle++;
         if (TO_EN && idle == TO) begin
            exp_err = 1'b1;
            pend.delete();
            idle = 0;
         end
      end
      exp_busy = (pend.size() != 0);
   endtask

   task automatic step(input logic s, input logic [7:0] d);
      @(negedge clk_i);
      rx_stb_i = s;
      rx_dat_i = d;
      model(s, d);
      @(posedge clk_i);
      #1;
      chk("stb_o", {31'b0, stb_o}, {31'b0, exp_stb});
      chk("busy_o", {31'b0, busy_o}, {31'b0, exp_busy});
      chk("err_o", {31'b0, err_o}, {31'b0, exp_err});
      if (exp_stb) begin
         chk("opc_o", {24'b0, opc_o}, {24'b0, exp_opc});
         chk("cmd_o", cmd_o, exp_cmd);
      end
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00);
   endtask

   task automatic do_reset();
      rx_stb_i = 1'b0;
      rst_in   = 1'b0;
      #2;
      chk("rst stb_o", {31'b0, stb_o}, 32'h0);
      chk("rst busy_o", {31'b0, busy_o}, 32'h0);
      chk("rst err_o", {31'b0, err_o}, 32'h0);
      chk("rst opc_o", {24'b0, opc_o}, 32'h0);
      chk("rst cmd_o", cmd_o, 32'h0);
      pend.delete();
      idle = 0;
      @(negedge clk_i);
      @(negedge clk_i);
      rst_in = 1'b1;
   endtask

   initial begin
      logic [7:0] b;
      int gap;
      #3;
      do_reset();

      // Short command
      step(1'b1, 8'h00);
      idle_n(2);

      // Long command, back to back
      step(1'b1, 8'hC0); step(1'b1, 8'h11); step(1'b1, 8'h22);
      step(1'b1, 8'h33); step(1'b1, 8'h44);
      idle_n(2);

      // Timeout abort, then a short command
      step(1'b1, 8'h80); step(1'b1, 8'hAA);
      idle_n(TO);
      step(1'b1, 8'h02);
      idle_n(2);

      // Bytes landing exactly on the timeout cycle
      step(1'b1, 8'h81);
      for (int k = 0; k < 4; k++) begin
         idle_n(TO - 1);
         step(1'b1, 8'h5A + 8'(k));
      end
      idle_n(2);

      // Reset in the middle of a long command
      step(1'b1, 8'hC1); step(1'b1, 8'h01);
      do_reset();
      idle_n(TO + 2);
      step(1'b1, 8'h01);
      idle_n(2);

      // Five short commands in a row
      for (int k = 0; k < 5; k++) step(1'b1, 8'h00);

      // New opcode in the same cycle the previous stb_o is high
      step(1'b1, 8'h90); step(1'b1, 8'h01); step(1'b1, 8'h02);
      step(1'b1, 8'h03); step(1'b1, 8'h04); step(1'b1, 8'h7F);
      idle_n(2);

      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 399) == 0) begin
            do_reset();
         end
         gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO + 3)) : 0;
         idle_n(gap);
         b = 8'($urandom);
         step(1'b1, b);
      end
      idle_n(TO + 2);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
